// File: rtl/note_sequencer.sv
// Background-music sequencer with live-key preemption and a note-gate output stage.
// Walks an external registered ROM and holds record_high low for a fixed gap on every new note.
module note_sequencer #(
  parameter int unsigned TICK_DIV   = 2500000,
  parameter int unsigned GAP_CYCLES = 8334,
  parameter int unsigned SEQ_LEN    = 32,
  parameter int unsigned IDX_W      = 5
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [31:0]      live_note,
  input  logic             bgm_start,
  input  logic             bgm_stop,
  output logic [IDX_W-1:0] seq_addr,
  input  logic [7:0]       seq_data,
  output logic [31:0]      note_out,
  output logic             record_high,
  output logic             is_play,
  output logic             src_live
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [4:0]  CODE_END  = 5'd30;
  localparam logic [4:0]  CODE_REST = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         dur_q, dur_d;
  logic [GAP_W-1:0]   sgap_q, sgap_d;
  logic [31:0]        bgm_note_q, bgm_note_d;

  logic [31:0]        note_out_q, note_out_d;
  logic               record_high_q, record_high_d;
  logic               is_play_q, is_play_d;
  logic               src_live_q, src_live_d;
  logic [GAP_W-1:0]   ogap_q, ogap_d;

  logic               live_valid;
  logic [31:0]        sel;
  logic               load_gap;

  // Sequencer state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tick_q     <= '0;
      dur_q      <= '0;
      sgap_q     <= '0;
      bgm_note_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      sgap_q     <= sgap_d;
      bgm_note_q <= bgm_note_d;
    end
  end

  // Sequencer next-state: fetch, latch, play for (dur+1) ticks, then a silent gap
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    sgap_d     = sgap_q;
    bgm_note_d = bgm_note_q;

    case (state_q)
      S_IDLE: begin
        bgm_note_d = '0;
        if (bgm_start) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        if (seq_data[4:0] == CODE_END) begin
          bgm_note_d = '0;
          state_d    = S_IDLE;
        end else begin
          dur_d      = seq_data[7:5];
          tick_d     = '0;
          bgm_note_d = (seq_data[4:0] == CODE_REST) ? 32'd0 : (32'(1) << seq_data[4:0]);
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_q == TICK_W'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (dur_q == 3'd0) begin
            bgm_note_d = '0;
            sgap_d     = GAP_W'(GAP_CYCLES - 1);
            state_d    = S_GAP;
          end else begin
            dur_d = dur_q - 3'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_GAP: begin
        bgm_note_d = '0;
        if (sgap_q == '0) begin
          idx_d   = (idx_q == IDX_W'(SEQ_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          sgap_d = sgap_q - GAP_W'(1);
        end
      end
      default: begin
        bgm_note_d = '0;
        state_d    = S_IDLE;
      end
    endcase

    // Restart from any active state; stop overrides everything and keeps idx
    if (bgm_start && (state_q != S_IDLE)) begin
      idx_d      = '0;
      bgm_note_d = '0;
      state_d    = S_FETCH;
    end
    if (bgm_stop) begin
      idx_d      = idx_q;
      bgm_note_d = '0;
      state_d    = S_IDLE;
    end
  end

  // Live request is honoured only when it is a clean one-hot in [29:0]
  always_comb begin
    live_valid = (live_note[31:30] == 2'b00) && (live_note[29:0] != 30'd0) &&
                 ((live_note[29:0] & (live_note[29:0] - 30'd1)) == 30'd0);
    sel        = live_valid ? live_note : bgm_note_q;
    load_gap   = (sel != 32'd0) && (sel != note_out_q);

    ogap_d = ogap_q;
    if (load_gap) begin
      ogap_d = GAP_W'(GAP_CYCLES);
    end else if (ogap_q != '0) begin
      ogap_d = ogap_q - GAP_W'(1);
    end

    note_out_d    = sel;
    record_high_d = (sel != 32'd0) && (ogap_d == '0);
    src_live_d    = live_valid;
    is_play_d     = (state_d != S_IDLE);
  end

  // Output stage registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      note_out_q    <= '0;
      record_high_q <= 1'b0;
      is_play_q     <= 1'b0;
      src_live_q    <= 1'b0;
      ogap_q        <= '0;
    end else begin
      note_out_q    <= note_out_d;
      record_high_q <= record_high_d;
      is_play_q     <= is_play_d;
      src_live_q    <= src_live_d;
      ogap_q        <= ogap_d;
    end
  end

  assign seq_addr    = idx_q;
  assign note_out    = note_out_q;
  assign record_high = record_high_q;
  assign is_play     = is_play_q;
  assign src_live    = src_live_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a small registered ROM model.
// Time points are counted in clock edges after each bgm_start pulse.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] live_note = 32'd0;
  logic        bgm_start = 1'b0;
  logic        bgm_stop = 1'b0;
  logic [1:0]  seq_addr;
  logic [7:0]  seq_data = 8'd0;
  logic [31:0] note_out;
  logic        record_high;
  logic        is_play;
  logic        src_live;

  logic [7:0]  rom [0:3];
  int          cyc = 0;
  int          base = 0;
  int          vectors = 0;
  int          miscompares = 0;

  note_sequencer #(
    .TICK_DIV   (4),
    .GAP_CYCLES (3),
    .SEQ_LEN    (4),
    .IDX_W      (2)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .live_note   (live_note),
    .bgm_start   (bgm_start),
    .bgm_stop    (bgm_stop),
    .seq_addr    (seq_addr),
    .seq_data    (seq_data),
    .note_out    (note_out),
    .record_high (record_high),
    .is_play     (is_play),
    .src_live    (src_live)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    seq_data <= rom[seq_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic start_bgm();
    @(negedge clk);
    bgm_start = 1'b1;
    base = cyc;
    @(negedge clk);
    bgm_start = 1'b0;
  endtask

  task automatic load_song(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    load_song(8'h40, 8'h05, 8'h1F, 8'h1E);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_note_out", note_out, 32'd0);
    check("rst_record_high", {31'd0, record_high}, 32'd0);
    check("rst_is_play", {31'd0, is_play}, 32'd0);
    check("rst_src_live", {31'd0, src_live}, 32'd0);
    check("rst_seq_addr", {30'd0, seq_addr}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Full song: 3-tick note 0, 1-tick note 5, rest, end
    start_bgm();
    check("s1_is_play", {31'd0, is_play}, 32'd1);
    check("s1_note_silent", note_out, 32'd0);
    at(3);  check("s1_pre_note", note_out, 32'd0);
    at(4);  check("s1_note_on", note_out, 32'd1);
    check("s1_gate_low0", {31'd0, record_high}, 32'd0);
    at(6);  check("s1_gate_low2", {31'd0, record_high}, 32'd0);
    at(7);  check("s1_gate_high", {31'd0, record_high}, 32'd1);
    at(15); check("s1_note_last", note_out, 32'd1);
    at(16); check("s1_note_off", note_out, 32'd0);
    check("s1_gate_off", {31'd0, record_high}, 32'd0);
    check("s1_play_gap", {31'd0, is_play}, 32'd1);
    at(18); check("s1_addr1", {30'd0, seq_addr}, 32'd1);
    at(20); check("s1_latch_silent", note_out, 32'd0);
    at(21); check("s1_note5", note_out, 32'h20);
    check("s1_note5_gate", {31'd0, record_high}, 32'd0);
    at(23); check("s1_note5_gate2", {31'd0, record_high}, 32'd0);
    at(24); check("s1_note5_gate_hi", {31'd0, record_high}, 32'd1);
    at(25); check("s1_note5_off", note_out, 32'd0);
    at(32); check("s1_rest_note", note_out, 32'd0);
    check("s1_rest_gate", {31'd0, record_high}, 32'd0);
    at(37); check("s1_end_play", {31'd0, is_play}, 32'd1);
    check("s1_end_addr", {30'd0, seq_addr}, 32'd3);
    at(38); check("s1_idle", {31'd0, is_play}, 32'd0);

    // Live preemption, invalid live codes, and same-note handover
    start_bgm();
    at(7);  check("s3_gate_high", {31'd0, record_high}, 32'd1);
    live_note = 32'h4;
    at(8);  check("s3_live_note", note_out, 32'h4);
    check("s3_src_live", {31'd0, src_live}, 32'd1);
    check("s3_live_gate", {31'd0, record_high}, 32'd0);
    at(10); check("s3_live_gate2", {31'd0, record_high}, 32'd0);
    at(11); check("s3_live_gate_hi", {31'd0, record_high}, 32'd1);
    live_note = 32'd0;
    at(12); check("s3_bgm_back", note_out, 32'd1);
    check("s3_src_bgm", {31'd0, src_live}, 32'd0);
    check("s3_back_gate", {31'd0, record_high}, 32'd0);
    at(15); check("s3_back_gate_hi", {31'd0, record_high}, 32'd1);
    at(16); check("s3_timing_kept", note_out, 32'd0);
    at(20); live_note = 32'h3;
    at(21); check("s4_twobit_note", note_out, 32'h20);
    check("s4_twobit_src", {31'd0, src_live}, 32'd0);
    live_note = 32'h4000_0000;
    at(24); check("s4_hibit_gate", {31'd0, record_high}, 32'd1);
    check("s4_hibit_src", {31'd0, src_live}, 32'd0);
    live_note = 32'h20;
    at(25); check("s4_hand_note", note_out, 32'h20);
    check("s4_hand_src", {31'd0, src_live}, 32'd1);
    check("s4_hand_gate", {31'd0, record_high}, 32'd1);
    live_note = 32'd0;
    at(26); check("s4_release", note_out, 32'd0);
    at(38); check("s4_idle", {31'd0, is_play}, 32'd0);

    // Start and stop together, then stop mid-PLAY
    @(negedge clk);
    bgm_start = 1'b1;
    bgm_stop  = 1'b1;
    @(negedge clk);
    bgm_start = 1'b0;
    bgm_stop  = 1'b0;
    check("s5_both_idle", {31'd0, is_play}, 32'd0);
    check("s5_both_addr", {30'd0, seq_addr}, 32'd3);
    @(negedge clk);
    check("s5_both_idle2", {31'd0, is_play}, 32'd0);
    start_bgm();
    at(8);  bgm_stop = 1'b1;
    at(9);  bgm_stop = 1'b0;
    check("s5_stop_idle", {31'd0, is_play}, 32'd0);
    check("s5_stop_note_held", note_out, 32'd1);
    check("s5_stop_gate_held", {31'd0, record_high}, 32'd1);
    at(10); check("s5_stop_note", note_out, 32'd0);
    check("s5_stop_gate", {31'd0, record_high}, 32'd0);

    // No end code: index wraps, then async reset mid-PLAY
    load_song(8'h00, 8'h01, 8'h02, 8'h03);
    start_bgm();
    at(4);  check("s6_note0", note_out, 32'h1);
    at(10); check("s6_addr1", {30'd0, seq_addr}, 32'd1);
    at(22); check("s6_note2", note_out, 32'h4);
    at(31); check("s6_note3", note_out, 32'h8);
    at(36); check("s6_addr3", {30'd0, seq_addr}, 32'd3);
    at(37); check("s6_wrap", {30'd0, seq_addr}, 32'd0);
    at(40); check("s6_wrap_note", note_out, 32'h1);
    check("s6_wrap_play", {31'd0, is_play}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("s6_arst_note", note_out, 32'd0);
    check("s6_arst_play", {31'd0, is_play}, 32'd0);
    check("s6_arst_gate", {31'd0, record_high}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s6_post_idle", {31'd0, is_play}, 32'd0);
    check("s6_post_note", note_out, 32'd0);
    check("s6_post_addr", {30'd0, seq_addr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
